// File: rtl/axil_master.sv
// AXI4-Lite initiator: turns a single-beat cmd/rsp handshake into AW/W/B or AR/R
// transactions, one outstanding at a time. All outputs are registered.
// Optional hung-slave watchdog: define AXIL_MST_TIMEOUT_EN.
module axil_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_W        = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  // write address channel
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic [2:0]        AW_PROT,
  // write data channel
  output logic              W_VALID,
  input  logic              W_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic [STRB_W-1:0] W_STRB,
  // write response channel
  input  logic              B_VALID,
  output logic              B_READY,
  input  logic [1:0]        B_RESP,
  // read address channel
  output logic              AR_VALID,
  input  logic              AR_READY,
  output logic [ADDR_W-1:0] AR_ADDR,
  output logic [2:0]        AR_PROT,
  // read data channel
  input  logic              R_VALID,
  output logic              R_READY,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } state_e;

  state_e state_q;
  logic   aw_done_q;
  logic   w_done_q;
  logic   we_q;

  // Handshake strobes; every one of them is gated by a registered VALID/READY.
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign aw_fire = AW_VALID & AW_READY;
  assign w_fire  = W_VALID & W_READY;
  assign b_fire  = B_VALID & B_READY;
  assign ar_fire = AR_VALID & AR_READY;
  assign r_fire  = R_VALID & R_READY;

  assign AW_PROT = 3'b000;
  assign AR_PROT = 3'b000;

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);
  logic [WdogW-1:0] wdog_q;
  logic             busy;
  assign busy = (state_q == StWrReq) || (state_q == StWrResp) ||
                (state_q == StRdReq) || (state_q == StRdResp);
`else
  // Watchdog compiled out; the limit parameter has no effect.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      we_q      <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      AW_VALID  <= 1'b0;
      AW_ADDR   <= '0;
      W_VALID   <= 1'b0;
      W_DATA    <= '0;
      W_STRB    <= '0;
      B_READY   <= 1'b0;
      AR_VALID  <= 1'b0;
      AR_ADDR   <= '0;
      R_READY   <= 1'b0;
`ifdef AXIL_MST_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            we_q      <= cmd_we;
`ifdef AXIL_MST_TIMEOUT_EN
            wdog_q    <= '0;
`endif
            if (cmd_we) begin
              AW_ADDR   <= cmd_addr;
              W_DATA    <= cmd_wdata;
              W_STRB    <= cmd_wstrb;
              AW_VALID  <= 1'b1;
              W_VALID   <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= StWrReq;
            end else begin
              AR_ADDR  <= cmd_addr;
              AR_VALID <= 1'b1;
              state_q  <= StRdReq;
            end
          end
        end
        StWrReq: begin
          // AW and W retire independently, in any order or together.
          if (aw_fire) AW_VALID <= 1'b0;
          if (w_fire)  W_VALID  <= 1'b0;
          aw_done_q <= aw_done_q | aw_fire;
          w_done_q  <= w_done_q | w_fire;
          if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
            B_READY <= 1'b1;
            state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (b_fire) begin
            B_READY   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= B_RESP;
            state_q   <= StRsp;
          end
        end
        StRdReq: begin
          if (ar_fire) begin
            AR_VALID <= 1'b0;
            R_READY  <= 1'b1;
            state_q  <= StRdResp;
          end
        end
        StRdResp: begin
          if (r_fire) begin
            R_READY   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b0;
            rsp_rdata <= R_DATA;
            rsp_resp  <= R_RESP;
            state_q   <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

`ifdef AXIL_MST_TIMEOUT_EN
      // Hung-slave abort: deliberately drops VALIDs without a handshake.
      if (busy) begin
        wdog_q <= wdog_q + 1'b1;
        if (wdog_q == WdogLast) begin
          AW_VALID  <= 1'b0;
          W_VALID   <= 1'b0;
          B_READY   <= 1'b0;
          AR_VALID  <= 1'b0;
          R_READY   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_we    <= we_q;
          rsp_rdata <= '0;
          rsp_resp  <= 2'b10;
          state_q   <= StRsp;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a small negedge-driven AXI-Lite slave.
// Define AXIL_MST_TIMEOUT_EN to also exercise the watchdog (limit set to 16).
module tb_axil_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AW_VALID, W_VALID, B_READY, AR_VALID, R_READY;
  logic [31:0] AW_ADDR, W_DATA, AR_ADDR;
  logic [3:0]  W_STRB;
  logic [2:0]  AW_PROT, AR_PROT;

  // Slave-driven inputs and slave state
  logic        AW_READY = 1'b0, W_READY = 1'b0, AR_READY = 1'b0;
  logic        B_VALID = 1'b0, R_VALID = 1'b0;
  logic [1:0]  B_RESP = 2'b00, R_RESP = 2'b00;
  logic [31:0] R_DATA = 32'h0;

  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 1;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  int   aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0;
  logic aw_pend = 0, w_pend = 0, ar_pend = 0, b_pend = 0, r_pend = 0;
  logic aw_got = 0, w_got = 0, wr_active = 0;
  int   aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, r_hs_cnt = 0;
  logic [31:0] cap_aw_addr = 0, cap_w_data = 0, cap_ar_addr = 0;
  logic [3:0]  cap_w_strb = 0;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;

  axil_master #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_we   (rsp_we),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .AW_VALID (AW_VALID),
    .AW_READY (AW_READY),
    .AW_ADDR  (AW_ADDR),
    .AW_PROT  (AW_PROT),
    .W_VALID  (W_VALID),
    .W_READY  (W_READY),
    .W_DATA   (W_DATA),
    .W_STRB   (W_STRB),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY),
    .B_RESP   (B_RESP),
    .AR_VALID (AR_VALID),
    .AR_READY (AR_READY),
    .AR_ADDR  (AR_ADDR),
    .AR_PROT  (AR_PROT),
    .R_VALID  (R_VALID),
    .R_READY  (R_READY),
    .R_DATA   (R_DATA),
    .R_RESP   (R_RESP)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave model: evaluated mid-cycle; *_pend marks a handshake at the next rising edge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      AW_READY = 0; W_READY = 0; AR_READY = 0; B_VALID = 0; R_VALID = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0;
      aw_got = 0; w_got = 0; wr_active = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0;
    end else begin
      if (aw_pend) begin aw_got = 1; aw_hs_cnt++; end
      if (w_pend) begin w_got = 1; w_hs_cnt++; end
      if (ar_pend) begin R_VALID = 1; R_DATA = cfg_rdata; R_RESP = cfg_rresp; end
      if (b_pend) begin B_VALID = 0; b_hs_cnt++; end
      if (r_pend) begin R_VALID = 0; r_hs_cnt++; end
      if (wr_active) begin
        b_wait++;
        if (b_wait >= cfg_b_dly) begin B_VALID = 1; B_RESP = cfg_bresp; wr_active = 0; end
      end
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; wr_active = 1; b_wait = 0; end
      if (AW_VALID) begin AW_READY = (aw_wait >= cfg_aw_dly); aw_wait++; end
      else begin AW_READY = 0; aw_wait = 0; end
      if (W_VALID) begin W_READY = (w_wait >= cfg_w_dly); w_wait++; end
      else begin W_READY = 0; w_wait = 0; end
      if (AR_VALID) begin AR_READY = (ar_wait >= cfg_ar_dly); ar_wait++; end
      else begin AR_READY = 0; ar_wait = 0; end
      aw_pend = AW_VALID && AW_READY;
      w_pend  = W_VALID && W_READY;
      ar_pend = AR_VALID && AR_READY;
      b_pend  = B_VALID && B_READY;
      r_pend  = R_VALID && R_READY;
      if (aw_pend) cap_aw_addr = AW_ADDR;
      if (w_pend) begin cap_w_data = W_DATA; cap_w_strb = W_STRB; end
      if (ar_pend) cap_ar_addr = AR_ADDR;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Presents one command; returns just after the accepting edge.
  task automatic start_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    @(negedge ACLK);
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(posedge ACLK);
    #1;
    acc_cyc = cyc;
    cmd_valid = 0;
  endtask

  // Latency = edges from accept to the edge that first samples rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (rsp_valid) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
    end
    if (lat < 0) check("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1;
    @(posedge ACLK);
    #1 rsp_ready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    int b0;
    ARESET = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;

    // Reset state
    @(negedge ACLK);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_vld_rdy", 32'({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY}), 32'd0);
    check("rst_regs", AW_ADDR | W_DATA | AR_ADDR | rsp_rdata, 32'd0);
    check("prot", 32'({AW_PROT, AR_PROT}), 32'd0);

    // Minimum-latency write
    start_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(lat);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_resp", 32'(rsp_resp), 32'd0);
    check("wr_we", 32'(rsp_we), 32'd1);
    check("wr_rdata", rsp_rdata, 32'd0);
    check("wr_awaddr", cap_aw_addr, 32'h10);
    check("wr_wdata", cap_w_data, 32'hDEADBEEF);
    check("wr_wstrb", 32'(cap_w_strb), 32'hF);
    finish_rsp();
    @(negedge ACLK);
    check("wr_idle", 32'(cmd_ready), 32'd1);

    // Minimum-latency read
    cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
    start_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_resp", 32'(rsp_resp), 32'd0);
    check("rd_we", 32'(rsp_we), 32'd0);
    check("rd_araddr", cap_ar_addr, 32'h10);
    finish_rsp();

    // Partial-strobe write with SLVERR
    cfg_bresp = 2'b10;
    start_cmd(1'b1, 32'h24, 32'h0000A5A5, 4'h3);
    wait_rsp(lat);
    check("wr2_resp", 32'(rsp_resp), 32'd2);
    check("wr2_awaddr", cap_aw_addr, 32'h24);
    check("wr2_wstrb", 32'(cap_w_strb), 32'h3);
    finish_rsp();
    cfg_bresp = 2'b00;

    // Channel skew: W accepted three cycles before AW
    cfg_aw_dly = 3;
    b0 = b_hs_cnt;
    start_cmd(1'b1, 32'h40, 32'h01234567, 4'hF);
    repeat (2) @(negedge ACLK);
    check("skew_w_dropped", 32'(W_VALID), 32'd0);
    check("skew_aw_held", 32'(AW_VALID), 32'd1);
    repeat (2) @(negedge ACLK);
    check("skew_aw_held2", 32'(AW_VALID), 32'd1);
    @(negedge ACLK);
    check("skew_aw_dropped", 32'(AW_VALID), 32'd0);
    wait_rsp(lat);
    check("skew_resp", 32'(rsp_resp), 32'd0);
    check("skew_wdata", cap_w_data, 32'h01234567);
    finish_rsp();
    @(negedge ACLK);
    check("skew_one_b", 32'(b_hs_cnt - b0), 32'd1);
    cfg_aw_dly = 0;

    // Response backpressure with RRESP = SLVERR
    cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
    start_cmd(1'b0, 32'h80, 32'h0, 4'h0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid, cmd_ready, 28'h0, rsp_resp}, {1'b1, 1'b0, 28'h0, 2'b10});
      check("bp_rdata", rsp_rdata, 32'h12345678);
      @(negedge ACLK);
    end
    finish_rsp();
    @(negedge ACLK);
    check("bp_idle", 32'({cmd_ready, rsp_valid}), 32'b10);
    cfg_rresp = 2'b00;

    // Reset while waiting for B
    cfg_b_dly = 100;
    start_cmd(1'b1, 32'h50, 32'hFFFF0000, 4'hC);
    cnt = 0;
    while (!B_READY && cnt < 20) begin @(negedge ACLK); cnt++; end
    check("rst_in_wr_resp", 32'(B_READY), 32'd1);
    @(posedge ACLK);
    #1 ARESET = 1;
    @(posedge ACLK);
    #1 ARESET = 0;
    @(negedge ACLK);
    check("mid_rst_vld_rdy", 32'({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY}), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge ACLK);
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    cfg_b_dly = 1;

    // Recovery after reset
    cfg_rdata = 32'hCAFEF00D;
    start_cmd(1'b0, 32'h60, 32'h0, 4'h0);
    wait_rsp(lat);
    check("post_rst_rdata", rsp_rdata, 32'hCAFEF00D);
    check("post_rst_latency", 32'(lat), 32'd3);
    finish_rsp();

`ifdef AXIL_MST_TIMEOUT_EN
    // Watchdog abort on a stuck AR channel
    cfg_ar_dly = 1000;
    cfg_rdata = 32'h55AA55AA;
    start_cmd(1'b0, 32'h70, 32'h0, 4'h0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (!AR_VALID) break;
      cnt++;
    end
    check("to_ar_cycles", 32'(cnt), 32'd16);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_resp", 32'(rsp_resp), 32'd2);
    check("to_rdata", rsp_rdata, 32'd0);
    finish_rsp();
    cfg_ar_dly = 0;
`endif

    repeat (2) @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
